// File: rtl/packet_replicator_n.sv
// AXI-Stream packet replicator: output 0 forwards every beat losslessly, outputs 1..N-1
// are capture copies with per-output enable, snap-length truncation and optional lossy mode.
module packet_replicator_n #(
   parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned NUM_OUTPUTS        = 3,
   parameter int unsigned SNAP_WIDTH         = 16,
   parameter int unsigned CNT_WIDTH          = 32
) (
   input  logic                                        axi_aclk,
   input  logic                                        axi_areset,
   input  logic [C_AXIS_DATA_WIDTH-1:0]                s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]              s_axis_tstrb,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]               s_axis_tuser,
   input  logic                                        s_axis_tvalid,
   output logic                                        s_axis_tready,
   input  logic                                        s_axis_tlast,
   output logic [NUM_OUTPUTS*C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [NUM_OUTPUTS*C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [NUM_OUTPUTS*C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic [NUM_OUTPUTS-1:0]                      m_axis_tvalid,
   input  logic [NUM_OUTPUTS-1:0]                      m_axis_tready,
   output logic [NUM_OUTPUTS-1:0]                      m_axis_tlast,
   input  logic [NUM_OUTPUTS-1:0]                      capture_en,
   input  logic [SNAP_WIDTH-1:0]                       snap_beats,
   input  logic                                        lossy_mode,
   output logic [NUM_OUTPUTS*CNT_WIDTH-1:0]            pkt_count,
   output logic [NUM_OUTPUTS*CNT_WIDTH-1:0]            drop_count
);

   localparam int unsigned STRB_W = C_AXIS_DATA_WIDTH / 8;
   localparam int unsigned DW     = C_AXIS_DATA_WIDTH;
   localparam int unsigned UW     = C_AXIS_TUSER_WIDTH;

   typedef enum logic [1:0] {ST_SOP, ST_BODY, ST_TRUNC} state_t;

   state_t                  state, state_nxt;
   logic [NUM_OUTPUTS-1:0]  active, active_nxt;
   logic [NUM_OUTPUTS-1:0]  slot_free, cap_ok, sop_set, live, load, drop_inc;
   logic [SNAP_WIDTH-1:0]   beat_cnt, beat_cnt_nxt, beat_num;
   logic [SNAP_WIDTH-1:0]   snap_q, snap_nxt, snap_cur;
   logic                    ready, accept, trunc_beat;

   // State register, active set and sampled snap length
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state    <= ST_SOP;
         active   <= '0;
         beat_cnt <= '0;
         snap_q   <= '0;
      end else begin
         state    <= state_nxt;
         active   <= active_nxt;
         beat_cnt <= beat_cnt_nxt;
         snap_q   <= snap_nxt;
      end
   end

   // Live set, input ready, next state and truncation decision
   always_comb begin
      state_nxt    = state;
      active_nxt   = active;
      beat_cnt_nxt = beat_cnt;
      snap_nxt     = snap_q;
      live         = NUM_OUTPUTS'(1);

      slot_free = ~m_axis_tvalid | m_axis_tready;
      cap_ok    = capture_en & (lossy_mode ? slot_free : {NUM_OUTPUTS{1'b1}});
      sop_set   = cap_ok | NUM_OUTPUTS'(1);
      snap_cur  = (state == ST_SOP) ? snap_beats : snap_q;
      beat_num  = (&beat_cnt) ? beat_cnt : beat_cnt + SNAP_WIDTH'(1);

      case (state)
         ST_SOP:   live = sop_set;
         ST_BODY:  live = active;
         default:  live = NUM_OUTPUTS'(1);
      endcase

      ready      = !axi_areset && (&(slot_free | ~live));
      accept     = s_axis_tvalid && ready;
      trunc_beat = (state != ST_TRUNC) && (snap_cur != '0) &&
                   (beat_num == snap_cur) && !s_axis_tlast;
      load       = accept ? live : '0;
      drop_inc   = (accept && state == ST_SOP) ?
                   (capture_en & ~cap_ok & ~NUM_OUTPUTS'(1)) : '0;

      if (accept) begin
         beat_cnt_nxt = s_axis_tlast ? '0 : beat_num;
         if (state == ST_SOP) begin
            active_nxt = sop_set;
            snap_nxt   = snap_beats;
         end
         if (s_axis_tlast)
            state_nxt = ST_SOP;
         else if (trunc_beat)
            state_nxt = ST_TRUNC;
         else if (state == ST_SOP)
            state_nxt = ST_BODY;
      end
      s_axis_tready = ready;
   end

   // Per-output register slots and statistics counters
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         m_axis_tvalid <= '0;
         m_axis_tlast  <= '0;
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tuser  <= '0;
         pkt_count     <= '0;
         drop_count    <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
            if (slot_free[i]) begin
               m_axis_tvalid[i] <= load[i];
               if (load[i]) begin
                  m_axis_tdata[i*DW +: DW]         <= s_axis_tdata;
                  m_axis_tstrb[i*STRB_W +: STRB_W] <= s_axis_tstrb;
                  m_axis_tuser[i*UW +: UW]         <= s_axis_tuser;
                  // capture copies end on the snap beat
                  m_axis_tlast[i] <= s_axis_tlast | (trunc_beat && (i != 0));
               end
            end
            if (m_axis_tvalid[i] && m_axis_tready[i] && m_axis_tlast[i])
               pkt_count[i*CNT_WIDTH +: CNT_WIDTH] <=
                  pkt_count[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
            if (drop_inc[i])
               drop_count[i*CNT_WIDTH +: CNT_WIDTH] <=
                  drop_count[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_packet_replicator_n.sv
// Directed, table-driven bench for packet_replicator_n with three outputs.
module tb_packet_replicator_n;

   localparam int unsigned DW = 256;
   localparam int unsigned UW = 128;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned N  = 3;
   localparam int unsigned CW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [DW-1:0]     s_tdata;
   logic [SW-1:0]     s_tstrb;
   logic [UW-1:0]     s_tuser;
   logic              s_tvalid, s_tready, s_tlast;
   logic [N*DW-1:0]   m_tdata;
   logic [N*SW-1:0]   m_tstrb;
   logic [N*UW-1:0]   m_tuser;
   logic [N-1:0]      m_tvalid, m_tready, m_tlast;
   logic [N-1:0]      cen;
   logic [15:0]       snap;
   logic              lossy;
   logic [N*CW-1:0]   pkt_cnt, drop_cnt;

   int total = 0;
   int bad   = 0;
   int row_no = 0;

   always #5 clk = ~clk;

   packet_replicator_n dut (
      .axi_aclk(clk), .axi_areset(rst),
      .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .capture_en(cen), .snap_beats(snap), .lossy_mode(lossy),
      .pkt_count(pkt_cnt), .drop_count(drop_cnt)
   );

   typedef struct {
      logic        vld, lst;
      logic [7:0]  id;
      logic [2:0]  rdy, cen;
      logic [15:0] snap;
      logic        lossy;
      logic        e_srdy;
      logic [2:0]  e_vld, e_lst;
      logic [7:0]  e_d0, e_d1, e_d2;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t r(logic vld, logic lst, logic [7:0] id, logic [2:0] rdy,
                              logic [2:0] ce, logic [15:0] sn, logic lo, logic srdy,
                              logic [2:0] evld, logic [2:0] elst,
                              logic [7:0] d0, logic [7:0] d1, logic [7:0] d2);
      vec_t v;
      v.vld = vld; v.lst = lst; v.id = id; v.rdy = rdy; v.cen = ce; v.snap = sn;
      v.lossy = lo; v.e_srdy = srdy; v.e_vld = evld; v.e_lst = elst;
      v.e_d0 = d0; v.e_d1 = d1; v.e_d2 = d2;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d actual=%h required=%h", nm, row_no, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic lst, input logic [7:0] id);
      s_tvalid = vld;
      s_tlast  = lst;
      s_tdata  = {8{32'(id)}};
      s_tuser  = {8{16'(id)}};
      s_tstrb  = {4{id}};
   endtask

   task automatic chk_out(input int i, input logic [7:0] id);
      logic [7:0] idv;
      idv = id;
      chk($sformatf("data%0d", i), 64'(m_tdata[i*DW +: DW] == {8{32'(idv)}}), 64'd1);
      chk($sformatf("user%0d", i), 64'(m_tuser[i*UW +: UW]), 64'({4{16'(idv)}}));
      chk($sformatf("strb%0d", i), 64'(m_tstrb[i*SW +: SW]), 64'({4{idv}}));
   endtask

   task automatic run_tbl();
      foreach (tbl[k]) begin
         @(posedge clk);
         #1;
         drive(tbl[k].vld, tbl[k].lst, tbl[k].id);
         m_tready = tbl[k].rdy;
         cen      = tbl[k].cen;
         snap     = tbl[k].snap;
         lossy    = tbl[k].lossy;
         @(negedge clk);
         row_no++;
         chk("s_tready", 64'(s_tready), 64'(tbl[k].e_srdy));
         chk("m_tvalid", 64'(m_tvalid), 64'(tbl[k].e_vld));
         for (int i = 0; i < 3; i++) begin
            if (tbl[k].e_vld[i]) begin
               chk($sformatf("m_tlast%0d", i), 64'(m_tlast[i]), 64'(tbl[k].e_lst[i]));
               chk_out(i, (i == 0) ? tbl[k].e_d0 : (i == 1) ? tbl[k].e_d1 : tbl[k].e_d2);
            end
         end
      end
      tbl.delete();
   endtask

   task automatic chk_cnt(input int p0, input int p1, input int p2, input int d1, input int d2);
      chk("pkt0", 64'(pkt_cnt[0*CW +: CW]), 64'(p0));
      chk("pkt1", 64'(pkt_cnt[1*CW +: CW]), 64'(p1));
      chk("pkt2", 64'(pkt_cnt[2*CW +: CW]), 64'(p2));
      chk("drop0", 64'(drop_cnt[0*CW +: CW]), 64'd0);
      chk("drop1", 64'(drop_cnt[1*CW +: CW]), 64'(d1));
      chk("drop2", 64'(drop_cnt[2*CW +: CW]), 64'(d2));
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      m_tready = 3'b111; cen = 3'b110; snap = 16'd0; lossy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_srdy", 64'(s_tready), 64'd0);
      chk("rst_vld", 64'(m_tvalid), 64'd0);
      chk_cnt(0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // plain 4-beat replication
      tbl.push_back(r(1,0,8'h01,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(1,0,8'h02,3'b111,3'b110,16'd0,0, 1,3'b111,3'b000, 8'h01,8'h01,8'h01));
      tbl.push_back(r(1,0,8'h03,3'b111,3'b110,16'd0,0, 1,3'b111,3'b000, 8'h02,8'h02,8'h02));
      tbl.push_back(r(1,1,8'h04,3'b111,3'b110,16'd0,0, 1,3'b111,3'b000, 8'h03,8'h03,8'h03));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b111,3'b111, 8'h04,8'h04,8'h04));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      run_tbl();
      chk_cnt(1, 1, 1, 0, 0);

      // snap_beats=2 on a 5-beat packet
      tbl.push_back(r(1,0,8'h11,3'b111,3'b110,16'd2,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(1,0,8'h12,3'b111,3'b110,16'd2,0, 1,3'b111,3'b000, 8'h11,8'h11,8'h11));
      tbl.push_back(r(1,0,8'h13,3'b111,3'b110,16'd2,0, 1,3'b111,3'b110, 8'h12,8'h12,8'h12));
      tbl.push_back(r(1,0,8'h14,3'b111,3'b110,16'd2,0, 1,3'b001,3'b000, 8'h13,8'h00,8'h00));
      tbl.push_back(r(1,1,8'h15,3'b111,3'b110,16'd2,0, 1,3'b001,3'b000, 8'h14,8'h00,8'h00));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b001,3'b001, 8'h15,8'h00,8'h00));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      run_tbl();
      chk_cnt(2, 2, 2, 0, 0);

      // lossless backpressure from output 2
      tbl.push_back(r(1,0,8'h21,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(1,0,8'h22,3'b011,3'b110,16'd0,0, 0,3'b111,3'b000, 8'h21,8'h21,8'h21));
      tbl.push_back(r(1,0,8'h22,3'b011,3'b110,16'd0,0, 0,3'b100,3'b000, 8'h00,8'h00,8'h21));
      tbl.push_back(r(1,0,8'h22,3'b011,3'b110,16'd0,0, 0,3'b100,3'b000, 8'h00,8'h00,8'h21));
      tbl.push_back(r(1,0,8'h22,3'b111,3'b110,16'd0,0, 1,3'b100,3'b000, 8'h00,8'h00,8'h21));
      tbl.push_back(r(1,0,8'h23,3'b111,3'b110,16'd0,0, 1,3'b111,3'b000, 8'h22,8'h22,8'h22));
      tbl.push_back(r(1,1,8'h24,3'b111,3'b110,16'd0,0, 1,3'b111,3'b000, 8'h23,8'h23,8'h23));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b111,3'b111, 8'h24,8'h24,8'h24));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      run_tbl();
      chk_cnt(3, 3, 3, 0, 0);

      // lossy mode: output 1 busy at SOP of the second packet
      tbl.push_back(r(1,1,8'h31,3'b111,3'b110,16'd0,1, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(1,0,8'h41,3'b101,3'b110,16'd0,1, 1,3'b111,3'b111, 8'h31,8'h31,8'h31));
      tbl.push_back(r(1,0,8'h42,3'b101,3'b110,16'd0,1, 1,3'b111,3'b010, 8'h41,8'h31,8'h41));
      tbl.push_back(r(1,1,8'h43,3'b111,3'b110,16'd0,1, 1,3'b111,3'b010, 8'h42,8'h31,8'h42));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,1, 1,3'b101,3'b101, 8'h43,8'h00,8'h43));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      run_tbl();
      chk_cnt(5, 4, 5, 1, 0);

      // capture_en change mid-packet applies to the next packet
      tbl.push_back(r(1,0,8'h51,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(1,0,8'h52,3'b111,3'b010,16'd0,0, 1,3'b111,3'b000, 8'h51,8'h51,8'h51));
      tbl.push_back(r(1,0,8'h53,3'b111,3'b010,16'd0,0, 1,3'b111,3'b000, 8'h52,8'h52,8'h52));
      tbl.push_back(r(1,1,8'h54,3'b111,3'b010,16'd0,0, 1,3'b111,3'b000, 8'h53,8'h53,8'h53));
      tbl.push_back(r(1,0,8'h61,3'b111,3'b010,16'd0,0, 1,3'b111,3'b111, 8'h54,8'h54,8'h54));
      tbl.push_back(r(1,1,8'h62,3'b111,3'b010,16'd0,0, 1,3'b011,3'b000, 8'h61,8'h61,8'h00));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b010,16'd0,0, 1,3'b011,3'b011, 8'h62,8'h62,8'h00));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      run_tbl();
      chk_cnt(7, 6, 6, 1, 0);

      // snap_beats=1: 1-beat packet is normal, 3-beat packet truncates on its first beat
      tbl.push_back(r(1,1,8'h71,3'b111,3'b110,16'd1,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd1,0, 1,3'b111,3'b111, 8'h71,8'h71,8'h71));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd1,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(1,0,8'h81,3'b111,3'b110,16'd1,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(1,0,8'h82,3'b111,3'b110,16'd1,0, 1,3'b111,3'b110, 8'h81,8'h81,8'h81));
      tbl.push_back(r(1,1,8'h83,3'b111,3'b110,16'd1,0, 1,3'b001,3'b000, 8'h82,8'h00,8'h00));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b001,3'b001, 8'h83,8'h00,8'h00));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      run_tbl();
      chk_cnt(9, 8, 8, 1, 0);

      // reset during beat 3 of a 6-beat packet
      tbl.push_back(r(1,0,8'h91,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(1,0,8'h92,3'b111,3'b110,16'd0,0, 1,3'b111,3'b000, 8'h91,8'h91,8'h91));
      run_tbl();
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 8'h93);
      chk("pre_rst_vld", 64'(m_tvalid), 64'h7);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_vld", 64'(m_tvalid), 64'd0);
      chk("mid_rst_srdy", 64'(s_tready), 64'd0);
      chk_cnt(0, 0, 0, 0, 0);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00);
      rst = 1'b0;

      tbl.push_back(r(1,0,8'hA1,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      tbl.push_back(r(1,1,8'hA2,3'b111,3'b110,16'd0,0, 1,3'b111,3'b000, 8'hA1,8'hA1,8'hA1));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b111,3'b111, 8'hA2,8'hA2,8'hA2));
      tbl.push_back(r(0,0,8'h00,3'b111,3'b110,16'd0,0, 1,3'b000,3'b000, 8'h00,8'h00,8'h00));
      run_tbl();
      chk_cnt(1, 1, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
